cmd_sequencer: RTL
==================

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO depth in entries; power of two, 2..64.
REQ-002 Parameter HOLD_CYCLES, default 50, clk cycles each command is held on the outputs; 1..65535.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 in_valid  input  1  command word present on in_cmd.
REQ-006 in_cmd  input  12  command word; [8:6] altitude, [5:3] dir axis 0, [2:0] dir axis 1, [11:9] reserved and ignored.
REQ-007 in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 altcmd  output  3  altitude command to dronectrl_top.
REQ-009 dircmd0  output  3  lateral left/right command to dronectrl_top dircmd[0].
REQ-010 dircmd1  output  3  lateral fwd/rev command to dronectrl_top dircmd[1].
REQ-011 cmd_strobe  output  1  one-cycle pulse in the first cycle a new command is driven.
REQ-012 busy  output  1  high while a command hold is in progress.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  number of buffered commands.
REQ-014 cmd_total  output  16  count of commands issued since reset.

Function
REQ-015 Push occurs when in_valid && in_ready; in_ready = (fifo_count < DEPTH), registered-state based, no combinational path from in_valid.
REQ-016 Pop only from entries present at cycle start; no same-cycle bypass of an incoming word to the outputs.
REQ-017 Simultaneous push and pop in one cycle leaves fifo_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-018 FSM states IDLE and HOLD only.
REQ-019 IDLE: if fifo_count > 0, pop; next cycle outputs show popped fields, cmd_strobe = 1, state HOLD, hold counter = HOLD_CYCLES-1; else remain IDLE.
REQ-020 HOLD: counter decrements each cycle; outputs stable; busy = 1.
REQ-021 HOLD with counter == 0 and fifo_count > 0: pop in that cycle, giving back-to-back commands exactly HOLD_CYCLES cycles apart, stay HOLD.
REQ-022 HOLD with counter == 0 and FIFO empty: go IDLE; busy = 0 next cycle.
REQ-023 cmd_total increments by 1 on every pop, wraps 0xFFFF -> 0x0000.
REQ-024 Push to a full FIFO is ignored (in_ready already low); push with in_valid low never alters state.
REQ-025 HOLD_CYCLES = 1: each command held one cycle; strobe high every cycle while FIFO drains.

Reset
REQ-026 reset high on posedge clk: FIFO emptied, pointers 0, state IDLE, counter 0.
REQ-027 Output reset values: altcmd = dircmd0 = dircmd1 = 3'b000 (hover), cmd_strobe = 0, busy = 0, fifo_count = 0, cmd_total = 0, in_ready = 1 from the first cycle after reset.
REQ-028 reset asserted mid-HOLD aborts the hold and discards all buffered commands; a push in the reset cycle is dropped.

Configuration
REQ-029 Macro CMDSEQ_HOVER_ON_IDLE_EN defined: on HOLD -> IDLE transition, altcmd/dircmd0/dircmd1 return to 3'b000 in the cycle busy falls.
REQ-030 Macro not defined: outputs retain the last issued command while IDLE until the next pop or reset.

Verification
REQ-031 Reset, push 12'h049 once -> after pop, altcmd=001, dircmd0=001, dircmd1=001, strobe 1 cycle, busy for exactly 50 cycles, cmd_total=1.
REQ-032 Push 3 words back-to-back while IDLE -> strobes at cycles t, t+50, t+100; fifo_count peaks at 2 in the cycle after the last push, then decrements by one per pop.
REQ-033 Push DEPTH+2 words with no drain gap -> in_ready low when fifo_count=8; extra words dropped; exactly 8 strobes follow after the in-flight command.
REQ-034 Assert reset 20 cycles into a hold with 3 queued -> next cycle outputs 000, fifo_count=0, busy=0, cmd_total=0, no further strobes.
REQ-035 Single command 12'h1C0 then drain, run with and without CMDSEQ_HOVER_ON_IDLE_EN -> altcmd returns to 000 at hold end when defined, stays 111 when not.
REQ-036 Preload cmd_total to 0xFFFF via 65535 pops with HOLD_CYCLES=1, one more pop -> cmd_total=0x0000.

Source files
------------

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: buffers 12-bit flight command words in a small FIFO and
// replays them to the drone controller. Each command is held on the outputs
// for HOLD_CYCLES clocks. When the FIFO is not empty, consecutive commands
// are issued back-to-back, exactly HOLD_CYCLES apart.
//
// Optional feature: define CMDSEQ_HOVER_ON_IDLE_EN to return all three
// command outputs to hover (3'b000) when the sequencer goes idle. When the
// macro is undefined, the last issued command stays on the outputs while idle.
module cmd_sequencer #(
  parameter int DEPTH       = 8,   // power of two, 2..64
  parameter int HOLD_CYCLES = 50   // 1..65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [11:0]              in_cmd,
  output logic                     in_ready,
  output logic [2:0]               altcmd,
  output logic [2:0]               dircmd0,
  output logic [2:0]               dircmd1,
  output logic                     cmd_strobe,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              cmd_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [15:0]    hold_cnt_q, hold_cnt_d;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [8:0]     mem_q [DEPTH];   // reserved bits [11:9] are not stored
  logic [2:0]     alt_q, dir0_q, dir1_q;
  logic           strobe_q;
  logic [15:0]    total_q;
  logic           push, pop;
  logic [8:0]     head;

  // Accept a word only when space was free at the start of the cycle.
  assign push = in_valid && in_ready;
  assign head = mem_q[rd_ptr_q];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values, independent of the order of the statements.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: decides when to pop, and reloads the hold counter.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    pop        = 1'b0;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_q == 16'd0) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) hold_cnt_d = HOLD_RELOAD;
  end

  // Output logic derived from registered state only (no path from in_valid).
  always_comb begin
    busy     = (state_q == HOLD);
    in_ready = (count_q < CW'(DEPTH));
  end

  // FIFO occupancy. A simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage. A word written during reset is orphaned by the pointer reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Validity is tracked only by the
    // pointers and the count, so clearing the data would add logic for nothing.
    if (push) mem_q[wr_ptr_q] <= in_cmd[8:0];
  end

  // Pointers, count and hold counter. Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_cnt_q <= 16'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Command output registers, issue strobe and issued-command total.
  always_ff @(posedge clk) begin
    if (reset) begin
      alt_q    <= 3'b000;
      dir0_q   <= 3'b000;
      dir1_q   <= 3'b000;
      strobe_q <= 1'b0;
      total_q  <= 16'd0;
    end else begin
      strobe_q <= pop;
      if (pop) begin
        alt_q   <= head[8:6];
        dir0_q  <= head[5:3];
        dir1_q  <= head[2:0];
        total_q <= total_q + 16'd1;
      end
`ifdef CMDSEQ_HOVER_ON_IDLE_EN
      else if (state_q == HOLD && state_d == IDLE) begin
        alt_q  <= 3'b000;
        dir0_q <= 3'b000;
        dir1_q <= 3'b000;
      end
`endif
    end
  end

  assign altcmd     = alt_q;
  assign dircmd0    = dir0_q;
  assign dircmd1    = dir1_q;
  assign cmd_strobe = strobe_q;
  assign fifo_count = count_q;
  assign cmd_total  = total_q;

endmodule
